handshake_constant_arbiter: RTL

//  Shares one registered constant-output channel between NUM_REQ control requesters.

---
 rtl/handshake_pkg.sv | 28 ++
 rtl/handshake_rr_arbiter.sv | 41 ++++
 rtl/handshake_constant_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// Shared helpers for handshake constant blocks:
// index-width derivation and constant-table slicing.
`ifndef HANDSHAKE_PKG_SV
`define HANDSHAKE_PKG_SV

// Select entry i of a packed table whose entries are w bits wide.
`define HS_CONST_SLICE(tbl, i, w) tbl[(i)*(w) +: (w)]

package handshake_pkg;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Width of a requester index; a single requester still gets one bit.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

`endif

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps,
// using a doubled request vector so the wrap is just a carry.
module handshake_rr_arbiter
    import handshake_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx
);

    localparam int W2 = 2 * NUM_REQ;

    logic [W2-1:0] one;
    logic [W2-1:0] req_dbl;
    logic [W2-1:0] below;
    logic [W2-1:0] masked;
    logic [W2-1:0] first;

    // Mask off requests below ptr, then isolate the lowest remaining bit.
    always_comb begin
        one     = {{(W2-1){1'b0}}, 1'b1};
        req_dbl = {req, req};
        below   = (one << ptr) - one;
        masked  = req_dbl & ~below;
        first   = masked & (~masked + one);
        grant   = first[NUM_REQ-1:0] | first[W2-1:NUM_REQ];
    end

    // Encode the one-hot grant into the requester index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) idx = i[ID_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/handshake_constant_arbiter.sv
// One registered output slot shared by NUM_REQ ctrl requesters;
// a granted token loads that requester's constant and index.
module handshake_constant_arbiter
    import handshake_pkg::*;
#(
    parameter int                          NUM_REQ     = 4,
    parameter int                          DATA_WIDTH  = 32,
    parameter int                          ID_WIDTH    = 2,
    parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_TABLE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ctrl_valid,
    output logic [NUM_REQ-1:0]    ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [ID_WIDTH-1:0]   outs_id,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0] rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] gidx;
    logic                can_load;
    logic                xfer;

    handshake_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req   (ctrl_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // Accept a token only when the slot is empty or draining, never in reset.
    always_comb begin
        can_load   = !outs_valid || outs_ready;
        ctrl_ready = grant & {NUM_REQ{can_load && rst}};
        xfer       = |(ctrl_valid & ctrl_ready);
    end

    // Output slot and fairness pointer; the pointer moves only on a transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outs       <= '0;
            outs_id    <= '0;
            outs_valid <= 1'b0;
            rr_ptr     <= '0;
        end else if (xfer) begin
            outs       <= `HS_CONST_SLICE(CONST_TABLE, gidx, DATA_WIDTH);
            outs_id    <= gidx;
            outs_valid <= 1'b1;
            rr_ptr     <= (gidx == LAST) ? '0 : gidx + 1'b1;
        end else if (outs_ready) begin
            outs_valid <= 1'b0;
        end
    end

endmodule
